tsmp_frame_buf: RTL and testbench

- Store-and-forward frame buffer directly downstream of the TSMP header-check/pass-through stage.
- Consumes that stage's 9-bit word stream: bit 8 is set on the head word and on the tail word of each frame; there is no backpressure on the input.
- Buffers whole frames in an internal RAM. A frame is released to the consumer only after its tail has been written.
- Frames that overflow are discarded whole, and a drop pulse is raised. Output uses a valid/ready handshake.

---
 rtl/tsmp_pkg.sv | 24 ++
 rtl/tsmp_sdp_ram.sv | 29 ++
 rtl/tsmp_frame_buf.sv | 184 ++++++++++++++++++
 tb/tb_tsmp_frame_buf.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tsmp_pkg.sv
// Shared TSMP definitions: delimiter position, ethertype match words and
// their offsets inside a frame, TSMP type codes and write-FSM states.
package tsmp_pkg;

    localparam int         TSMP_DELIM_BIT  = 8;
    localparam logic [8:0] TSMP_ETH_HI     = 9'h0ff;
    localparam logic [8:0] TSMP_ETH_LO     = 9'h001;
    localparam int         TSMP_ETH_HI_OFS = 12;
    localparam int         TSMP_ETH_LO_OFS = 13;

    typedef enum logic [1:0] {
        TSMP_NONE   = 2'd0,
        TSMP_READ   = 2'd1,
        TSMP_WRITE  = 2'd2,
        TSMP_CONFIG = 2'd3
    } tsmp_type_e;

    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        RECV_S = 2'd1,
        DROP_S = 2'd2
    } wr_state_e;

endpackage

// File: rtl/tsmp_sdp_ram.sv
// Simple dual-port RAM, one write port and one read port with a
// registered (1-cycle) read. The read register holds its value until
// the next read enable, which the buffer relies on as a pipeline stage.
module tsmp_sdp_ram #(
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] iv_waddr,
    input  logic [DATA_WIDTH-1:0] iv_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] iv_raddr,
    output logic [DATA_WIDTH-1:0] ov_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    // write port
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[iv_waddr] <= iv_wdata;
    end

    // registered read port, holds when not enabled
    always_ff @(posedge i_clk) begin
        if (i_re) ov_rdata <= r_mem[iv_raddr];
    end

endmodule

// File: rtl/tsmp_frame_buf.sv
// Store-and-forward TSMP frame buffer. Frames are written speculatively at
// wptr and become visible to the reader only when the tail commits cptr.
// Optional macro TSMP_FILTER_EN: commit only frames carrying the TSMP
// ethertype words (0x0ff, 0x001) at word offsets 12/13.
module tsmp_frame_buf
    import tsmp_pkg::*;
#(
    parameter int DATA_WIDTH = 9,
    parameter int ADDR_WIDTH = 9,
    parameter int FCNT_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] iv_data,
    input  logic                  i_data_wr,
    output logic [DATA_WIDTH-1:0] ov_data,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    output logic                  o_frame_drop,
    output logic [FCNT_WIDTH-1:0] ov_frame_cnt
);

    localparam int                  DB    = DATA_WIDTH - 1;
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [FCNT_WIDTH-1:0] FMAX = '1;

    logic [ADDR_WIDTH:0]   r_wptr, r_cptr, r_rptr;
    wr_state_e             r_state;
    logic [FCNT_WIDTH-1:0] r_fcnt;
    logic                  r_drop, r_rd_vld, r_out_in_frame, r_dvld;
    logic [DATA_WIDTH-1:0] r_dout, w_rdata;
    logic w_full, w_delim, w_we, w_commit, w_drop, w_pass;
    logic w_avail, w_adv, w_re, w_acc_delim, w_dec;

    assign w_full       = (r_wptr - r_rptr) == DEPTH;
    assign w_delim      = iv_data[DB];
    assign ov_data      = r_dout;
    assign o_data_valid = r_dvld;
    assign o_frame_drop = r_drop;
    assign ov_frame_cnt = r_fcnt;

`ifdef TSMP_FILTER_EN
    logic [ADDR_WIDTH:0] r_idx;
    logic                r_ok_hi, r_ok_lo;

    // word index and ethertype match flags of the frame being received
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx   <= '0;
            r_ok_hi <= 1'b0;
            r_ok_lo <= 1'b0;
        end else if (w_we) begin
            if (r_state == IDLE_S) begin
                r_idx   <= (ADDR_WIDTH+1)'(1);
                r_ok_hi <= 1'b0;
                r_ok_lo <= 1'b0;
            end else begin
                r_idx <= r_idx + 1'b1;
                if (r_idx == (ADDR_WIDTH+1)'(TSMP_ETH_HI_OFS))
                    r_ok_hi <= iv_data == DATA_WIDTH'(TSMP_ETH_HI);
                if (r_idx == (ADDR_WIDTH+1)'(TSMP_ETH_LO_OFS))
                    r_ok_lo <= iv_data == DATA_WIDTH'(TSMP_ETH_LO);
            end
        end
    end
    // both match words sit in the body, so this also rejects frames < 14 words
    assign w_pass = r_ok_hi && r_ok_lo;
`else
    assign w_pass = 1'b1;
`endif

    // per-word write decisions: store, commit at tail, or discard the frame
    always_comb begin
        w_we     = 1'b0;
        w_commit = 1'b0;
        w_drop   = 1'b0;
        if (i_data_wr) begin
            case (r_state)
                IDLE_S: begin
                    // a head arriving into a buffer full of committed data
                    // has nowhere to go; drop the whole frame
                    if (w_delim) begin
                        if (w_full) w_drop = 1'b1;
                        else        w_we   = 1'b1;
                    end
                end
                RECV_S: begin
                    if (w_full) begin
                        w_drop = 1'b1;
                    end else begin
                        w_we = 1'b1;
                        if (w_delim) begin
                            if (w_pass && r_fcnt != FMAX) w_commit = 1'b1;
                            else                          w_drop   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // write FSM, write/commit pointers and registered drop pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE_S;
            r_wptr  <= '0;
            r_cptr  <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= w_drop;
            if (w_we)     r_wptr <= r_wptr + 1'b1;
            if (w_commit) r_cptr <= r_wptr + 1'b1;
            if (w_drop)   r_wptr <= r_cptr;
            if (i_data_wr) begin
                case (r_state)
                    IDLE_S: if (w_delim) r_state <= w_full ? DROP_S : RECV_S;
                    // a tail that hits a full buffer still ends the frame,
                    // so the next head is not swallowed by DROP_S
                    RECV_S: if (w_delim)     r_state <= IDLE_S;
                            else if (w_full) r_state <= DROP_S;
                    DROP_S: if (w_delim) r_state <= IDLE_S;
                    default: r_state <= IDLE_S;
                endcase
            end
        end
    end

    // read side: RAM register is stage 1, output register is stage 2
    assign w_avail     = r_rptr != r_cptr;
    assign w_adv       = !r_dvld || i_data_ready;
    assign w_re        = w_avail && (!r_rd_vld || w_adv);
    assign w_acc_delim = r_dvld && i_data_ready && r_dout[DB];
    assign w_dec       = w_acc_delim && r_out_in_frame;

    // prefetch pipeline and output register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rptr         <= '0;
            r_rd_vld       <= 1'b0;
            r_dvld         <= 1'b0;
            r_dout         <= '0;
            r_out_in_frame <= 1'b0;
        end else begin
            if (w_re) r_rptr <= r_rptr + 1'b1;
            r_rd_vld <= w_re || (r_rd_vld && !w_adv);
            if (r_rd_vld && w_adv) begin
                r_dout <= w_rdata;
                r_dvld <= 1'b1;
            end else if (i_data_ready) begin
                r_dvld <= 1'b0;
            end
            // head and tail both carry the delimiter; alternate to tell them apart
            if (w_acc_delim) r_out_in_frame <= !r_out_in_frame;
        end
    end

    // committed-frame counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fcnt <= '0;
        end else begin
            case ({w_commit, w_dec})
                2'b10:   r_fcnt <= r_fcnt + 1'b1;
                2'b01:   r_fcnt <= r_fcnt - 1'b1;
                default: ;
            endcase
        end
    end

    tsmp_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk    (i_clk),
        .i_we     (w_we),
        .iv_waddr (r_wptr[ADDR_WIDTH-1:0]),
        .iv_wdata (iv_data),
        .i_re     (w_re),
        .iv_raddr (r_rptr[ADDR_WIDTH-1:0]),
        .ov_rdata (w_rdata)
    );

endmodule

// File: tb/tb_tsmp_frame_buf.sv
// Scoreboard bench for tsmp_frame_buf: the driver predicts each frame's
// fate from the frame rules and queues expected words; a monitor pops and
// compares every accepted output word and checks stall stability.
module tb_tsmp_frame_buf;

    localparam int DEPTH = 512;
    typedef logic [8:0] wq_t[$];

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [8:0] iv_data = '0;
    logic       i_data_wr = 1'b0;
    logic [8:0] ov_data;
    logic       o_data_valid;
    logic       i_data_ready;
    logic       o_frame_drop;
    logic [7:0] ov_frame_cnt;

    int checks = 0, errors = 0;
    int drop_seen = 0, exp_drops = 0, peak = 0, rdy_mode = 0;
    int last_drop_idx = -1;
    logic [8:0] exp_q[$];

    tsmp_frame_buf #(.DATA_WIDTH(9), .ADDR_WIDTH(9), .FCNT_WIDTH(8)) dut (
        .i_clk(clk), .i_rst(i_rst), .iv_data(iv_data), .i_data_wr(i_data_wr),
        .ov_data(ov_data), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
        .o_frame_drop(o_frame_drop), .ov_frame_cnt(ov_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference rule: a frame commits if it fits and (with the filter) carries
    // the ethertype words at offsets 12/13
    function automatic bit model_commit(input wq_t fr);
        if (fr.size() < 2 || fr.size() > DEPTH) return 1'b0;
`ifdef TSMP_FILTER_EN
        if (fr.size() < 14) return 1'b0;
        if (fr[12] != 9'h0ff || fr[13] != 9'h001) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic wq_t mk(input int len, input bit tsmp);
        wq_t fr;
        for (int i = 0; i < len; i++) begin
            logic [8:0] w;
            w = {(i == 0 || i == len - 1), 8'($urandom)};
            if (tsmp && i == 12 && len > 14) w = 9'h0ff;
            if (tsmp && i == 13 && len > 14) w = 9'h001;
            fr.push_back(w);
        end
        return fr;
    endfunction

    // ready generator
    initial begin
        i_data_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: i_data_ready = 1'b1;
                1: i_data_ready = !i_data_ready;
                2: i_data_ready = ($urandom_range(99) < 60);
                default: i_data_ready = 1'b0;
            endcase
        end
    end

    // monitor: pop-and-compare on every accepted word
    initial begin
        logic       stall_p;
        logic [8:0] stall_d;
        stall_p = 1'b0;
        stall_d = '0;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                stall_p = 1'b0;
            end else begin
                if (o_frame_drop) drop_seen++;
                if (int'(ov_frame_cnt) > peak) peak = int'(ov_frame_cnt);
                if (stall_p) check("hold_stable", {o_data_valid, ov_data}, {1'b1, stall_d});
                if (o_data_valid && i_data_ready) begin
                    if (exp_q.size() == 0) check("unexpected_word", ov_data, -1);
                    else check("out_word", ov_data, exp_q.pop_front());
                end
                stall_p = o_data_valid && !i_data_ready;
                stall_d = ov_data;
            end
        end
    end

    task automatic drive_word(input logic [8:0] w, input int idx);
        @(posedge clk); #1;
        if (o_frame_drop) last_drop_idx = idx - 1;
        iv_data = w;
        i_data_wr = 1'b1;
    endtask

    task automatic send(input wq_t fr, input int gap_pct);
        int n = 0;
        while (exp_q.size() + fr.size() > 480 && fr.size() <= DEPTH && n < 5000) begin
            @(posedge clk); n++;
        end
        if (n >= 5000) check("space_wait_timeout", n, 0);
        if (model_commit(fr)) foreach (fr[i]) exp_q.push_back(fr[i]);
        else exp_drops++;
        last_drop_idx = -1;
        foreach (fr[i]) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                @(posedge clk); #1;
                i_data_wr = 1'b0;
            end
            drive_word(fr[i], i);
        end
        @(posedge clk); #1;
        if (o_frame_drop) last_drop_idx = fr.size() - 1;
        i_data_wr = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || o_data_valid) && n < 4000) begin
            @(posedge clk); n++;
        end
        repeat (4) @(posedge clk);
        check({nm, "_drained"}, exp_q.size(), 0);
        check({nm, "_cnt_zero"}, ov_frame_cnt, 0);
        check({nm, "_drops"}, drop_seen, exp_drops);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        i_rst = 1'b1;
        i_data_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1 i_rst = 1'b0;
    endtask

    initial begin
        wq_t fr, fr2;
        int  nok, d0;

        do_reset();
        @(negedge clk);
        check("rst_valid", o_data_valid, 0);
        check("rst_data", ov_data, 0);
        check("rst_drop", o_frame_drop, 0);
        check("rst_cnt", ov_frame_cnt, 0);

        // 1: 20-word frame, ready high
        rdy_mode = 0; peak = 0;
        fr = {};
        fr.push_back(9'h1aa);
        for (int i = 0; i < 18; i++) fr.push_back(9'(i));
        fr.push_back(9'h155);
        nok = model_commit(fr);
        send(fr, 0);
        drain("t1");
        check("t1_peak", peak, nok);

        // 2: oversize frame with consumer stalled, then a short frame
        rdy_mode = 3;
        repeat (3) @(posedge clk);
        d0 = drop_seen;
        send(mk(600, 1'b0), 0);
        repeat (3) @(posedge clk);
        check("t2_drop_once", drop_seen - d0, 1);
        check("t2_drop_at", last_drop_idx, 512);
        check("t2_no_out", exp_q.size(), 0);
        fr = mk(4, 1'b0);
        nok = model_commit(fr);
        send(fr, 0);
        repeat (4) @(posedge clk);
        check("t2_cnt_held", ov_frame_cnt, nok);
        rdy_mode = 0;
        drain("t2");

        // 3: two back-to-back 8-word frames, ready toggling
        rdy_mode = 1; peak = 0;
        fr = mk(8, 1'b0);
        fr2 = mk(8, 1'b0);
        nok = model_commit(fr) + model_commit(fr2);
        send(fr, 0);
        send(fr2, 0);
        drain("t3");
        check("t3_peak", peak, nok);

        // 4: stray words in IDLE, then a 3-word frame
        rdy_mode = 0;
        drive_word(9'h033, 0);
        drive_word(9'h044, 1);
        send('{9'h1c3, 9'h07e, 9'h13c}, 0);
        drain("t4");

        // 5: reset mid-frame, then a 4-word frame
        for (int i = 0; i < 5; i++) drive_word((i == 0) ? 9'h1ee : 9'(i), i);
        do_reset();
        @(negedge clk);
        check("t5_cnt_after_rst", ov_frame_cnt, 0);
        check("t5_valid_after_rst", o_data_valid, 0);
        send('{9'h111, 9'h022, 9'h033, 9'h144}, 0);
        drain("t5");

        // 6: ethertype-matching 64-word frame, then one with word 13 spoiled
        rdy_mode = 3;
        fr = mk(64, 1'b1);
        fr2 = fr;
        fr2[13] = 9'h000;
        nok = model_commit(fr);
        send(fr, 0);
        repeat (4) @(posedge clk);
        check("t6_cnt_a", ov_frame_cnt, nok);
        d0 = drop_seen;
        send(fr2, 0);
        repeat (4) @(posedge clk);
        check("t6_cnt_b", ov_frame_cnt, nok + model_commit(fr2));
        check("t6_drop_b", drop_seen - d0, model_commit(fr2) ? 0 : 1);
        rdy_mode = 0;
        drain("t6");

        // random traffic
        rdy_mode = 2;
        for (int k = 0; k < 40; k++)
            send(mk($urandom_range(40, 2), $urandom_range(1)), $urandom_range(30));
        rdy_mode = 0;
        drain("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
